// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit scheduler: frame width, default sizing, FSM encoding.
package i2s_pkg;

    localparam int I2S_FRAME_W     = 32;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_START_LEVEL = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO; pointers carry one extra wrap bit.
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = I2S_FRAME_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset && do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/i2s_tx_sched.sv
// Two-source round-robin frame scheduler feeding an I2S transmitter, paced by synchronised WSelect.
// Optional underrun counter output enabled by defining I2S_TX_SCHED_UNDERRUN_CNT_EN.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int START_LEVEL = DEF_START_LEVEL,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   run_en,
    input  logic [I2S_FRAME_W-1:0] s0_data,
    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [I2S_FRAME_W-1:0] s1_data,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    input  logic                   tx_ws,
    output logic [I2S_FRAME_W-1:0] tx_data,
    output logic                   tx_enable,
    output logic                   underrun,
    output logic [LW-1:0]          fifo_level,
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    output logic [15:0]            underrun_cnt,
`endif
    output logic [1:0]             state
);

    localparam logic [LW-1:0] START_LV = LW'(START_LEVEL);

    state_t                   cur, nxt;
    logic                     ws_s1, ws_s2, ws_rise;
    logic                     rr_ptr, can_push, push, pop, full, empty;
    logic [I2S_FRAME_W-1:0]   din, dout;
    logic                     ld_head, ld_zero, uflow, en_nx;

    // tx_ws is asynchronous: two-flop synchroniser, rise seen 2-3 CLK late
    always_ff @(posedge CLK) begin
        if (!reset) begin
            ws_s1 <= 1'b0;
            ws_s2 <= 1'b0;
        end else begin
            ws_s1 <= tx_ws;
            ws_s2 <= ws_s1;
        end
    end
    assign ws_rise = ws_s1 & ~ws_s2;

    // rr_ptr names the source that wins a tie
    assign can_push = reset & ~full;
    assign s0_ready = can_push & s0_valid & (~s1_valid | ~rr_ptr);
    assign s1_ready = can_push & s1_valid & (~s0_valid |  rr_ptr);
    assign push     = s0_ready | s1_ready;
    assign din      = s1_ready ? s1_data : s0_data;

    always_ff @(posedge CLK) begin
        if (!reset)        rr_ptr <= 1'b0;
        else if (s0_ready) rr_ptr <= 1'b1;
        else if (s1_ready) rr_ptr <= 1'b0;
    end

    i2s_frame_fifo #(.DEPTH(DEPTH), .W(I2S_FRAME_W)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (!reset) cur <= ST_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        pop     = 1'b0;
        ld_head = 1'b0;
        ld_zero = 1'b0;
        uflow   = 1'b0;
        en_nx   = tx_enable;
        case (cur)
            ST_IDLE: begin
                en_nx = 1'b0;
                if (run_en) nxt = ST_PRIME;
            end
            ST_PRIME: begin
                en_nx = 1'b0;
                if (!run_en) begin
                    nxt = ST_IDLE;
                end else if (fifo_level >= START_LV) begin
                    pop     = 1'b1;
                    ld_head = 1'b1;
                    en_nx   = 1'b1;
                    nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                en_nx = 1'b1;
                if (ws_rise) begin
                    if (empty) begin
                        ld_zero = 1'b1;
                        uflow   = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        ld_head = 1'b1;
                    end
                end
                if (!run_en) nxt = ST_STOP;
            end
            ST_STOP: begin
                // finish the frame in flight, then go quiet
                if (ws_rise) begin
                    en_nx   = 1'b0;
                    ld_zero = 1'b1;
                    nxt     = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            tx_data   <= '0;
            tx_enable <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            tx_enable <= en_nx;
            underrun  <= uflow;
            if (ld_head)      tx_data <= dout;
            else if (ld_zero) tx_data <= '0;
        end
    end

`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge CLK) begin
        if (!reset)                                underrun_cnt <= '0;
        else if (cur == ST_IDLE && nxt == ST_PRIME) underrun_cnt <= '0;
        else if (uflow && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

    assign state = cur;

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Self-checking bench for i2s_tx_sched: directed scenarios plus randomized traffic against a queue model.
module tb_i2s_tx_sched;
    import i2s_pkg::*;

    localparam int DEPTH = 4;
    localparam int START_LEVEL = 2;
    localparam int LW = $clog2(DEPTH) + 1;

    logic        CLK = 1'b0, reset = 1'b0, run_en = 1'b0, tx_ws = 1'b0;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        s0_ready, s1_ready, tx_enable, underrun;
    logic [31:0] tx_data;
    logic [LW-1:0] fifo_level;
    logic [1:0]  state;
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    i2s_tx_sched #(.DEPTH(DEPTH), .START_LEVEL(START_LEVEL)) dut (
        .CLK(CLK), .reset(reset), .run_en(run_en),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .tx_ws(tx_ws), .tx_data(tx_data), .tx_enable(tx_enable),
        .underrun(underrun), .fifo_level(fifo_level),
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .state(state)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    bit chk_en = 1'b0;
    int ws_half = 10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of frames and a playback mode, updated per clock edge.
    logic [31:0] q[$];
    bit          m_ptr;
    int          m_mode;
    bit          m_h1, m_h2;
    logic [31:0] m_data;
    bit          m_en, m_und;
    int          m_cnt;

    always @(posedge CLK) begin : model
        bit rise;
        int g;
        int lvl;
        if (!reset) begin
            q.delete();
            m_ptr = 0; m_mode = 0; m_h1 = 0; m_h2 = 0;
            m_data = '0; m_en = 0; m_und = 0; m_cnt = 0;
        end else begin
            rise = m_h1 && !m_h2;
            lvl  = q.size();
            g    = -1;
            if (lvl < DEPTH) begin
                if (s0_valid && s1_valid) g = int'(m_ptr);
                else if (s0_valid)       g = 0;
                else if (s1_valid)       g = 1;
            end
            m_und = 0;
            case (m_mode)
                0: begin
                    m_en = 0;
                    if (run_en) begin m_mode = 1; m_cnt = 0; end
                end
                1: begin
                    if (!run_en) m_mode = 0;
                    else if (lvl >= START_LEVEL) begin
                        m_data = q.pop_front(); m_en = 1; m_mode = 2;
                    end
                end
                2: begin
                    if (rise) begin
                        if (lvl == 0) begin
                            m_data = '0; m_und = 1;
                            if (m_cnt < 65535) m_cnt++;
                        end else m_data = q.pop_front();
                    end
                    if (!run_en) m_mode = 3;
                end
                default: begin
                    if (rise) begin m_en = 0; m_data = '0; m_mode = 0; end
                end
            endcase
            if (g == 0)      begin q.push_back(s0_data); m_ptr = 1; end
            else if (g == 1) begin q.push_back(s1_data); m_ptr = 0; end
            m_h2 = m_h1;
            m_h1 = tx_ws;
        end
    end

    always @(negedge CLK) begin : compare
        if (chk_en) begin
            chk("tx_data",    tx_data, m_data);
            chk("tx_enable",  32'(tx_enable), 32'(m_en));
            chk("underrun",   32'(underrun), 32'(m_und));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            chk("state",      32'(state), 32'(m_mode));
            chk("s0_ready",   32'(s0_ready),
                32'(reset && q.size() < DEPTH && s0_valid && (!s1_valid || !m_ptr)));
            chk("s1_ready",   32'(s1_ready),
                32'(reset && q.size() < DEPTH && s1_valid && (!s0_valid || m_ptr)));
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
            chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
        end
    end

    initial begin : ws_gen
        int c;
        c = 0;
        forever begin
            @(posedge CLK); #3;
            c++;
            if (c >= ws_half) begin c = 0; tx_ws = ~tx_ws; end
        end
    end

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    initial begin : stim
        int n;
        // 1: reset with a valid source and run request
        reset = 1'b0; s0_valid = 1'b1; s0_data = 32'hDEAD0001; run_en = 1'b1;
        tick(); chk_en = 1'b1;
        tick(); tick(); #1;
        chk("rst state", 32'(state), 32'd0);
        chk("rst tx_enable", 32'(tx_enable), 32'd0);
        chk("rst tx_data", tx_data, 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst s0_ready", 32'(s0_ready), 32'd0);
        run_en = 1'b0; reset = 1'b1; #1;
        chk("post-rst s0_ready", 32'(s0_ready), 32'd1);
        tick(); s0_valid = 1'b0;
        chk("post-rst level", 32'(fifo_level), 32'd1);

        // 2: both sources valid, grants alternate until full
        reset = 1'b0; tick(); reset = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0_data = 32'hA000_0000 + i; s1_data = 32'hB000_0000 + i; #1;
            chk("rr s0", 32'(s0_ready), 32'(i % 2 == 0));
            chk("rr s1", 32'(s1_ready), 32'(i % 2 == 1));
            tick();
        end
        #1;
        chk("full level", 32'(fifo_level), 32'd4);
        chk("full s0_ready", 32'(s0_ready), 32'd0);
        chk("full s1_ready", 32'(s1_ready), 32'd0);
        s0_valid = 1'b0; s1_valid = 1'b0;

        // 3: preload two frames then start playback
        reset = 1'b0; tick(); reset = 1'b1;
        s0_valid = 1'b1; s0_data = 32'h11112222; tick();
        s0_valid = 1'b0; s1_valid = 1'b1; s1_data = 32'h33334444; tick();
        s1_valid = 1'b0; run_en = 1'b1;
        n = 0;
        while (state != 2'(ST_RUN) && n < 20) begin tick(); n++; end
        chk("reach RUN", 32'(state), 32'(ST_RUN));
        chk("first frame", tx_data, 32'h11112222);
        chk("run enable", 32'(tx_enable), 32'd1);
        n = 0;
        while (tx_data == 32'h11112222 && n < 60) begin tick(); n++; end
        chk("second frame", tx_data, 32'h33334444);

        // 4: FIFO empty at the next frame boundary
        n = 0;
        while (!underrun && n < 60) begin tick(); n++; end
        chk("underrun pulse", 32'(underrun), 32'd1);
        chk("underrun data", tx_data, 32'd0);
        chk("underrun level", 32'(fifo_level), 32'd0);
`ifdef I2S_TX_SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif
        // 5: refill two frames and drop run_en mid-frame
        s0_valid = 1'b1; s0_data = 32'h55550001; tick();
        chk("underrun one cycle", 32'(underrun), 32'd0);
        s0_data = 32'h55550002; tick();
        s0_valid = 1'b0; run_en = 1'b0; tick();
        chk("STOP state", 32'(state), 32'(ST_STOP));
        chk("STOP enable", 32'(tx_enable), 32'd1);
        n = 0;
        while (state != 2'(ST_IDLE) && n < 60) begin tick(); n++; end
        chk("back to IDLE", 32'(state), 32'(ST_IDLE));
        chk("IDLE enable", 32'(tx_enable), 32'd0);
        chk("IDLE data", tx_data, 32'd0);
        chk("kept level", 32'(fifo_level), 32'd2);

        // 6: reset in RUN with three frames queued
        run_en = 1'b1; tick(); tick();
        s0_valid = 1'b1; s0_data = 32'h66660001; tick();
        s0_data = 32'h66660002; tick();
        s0_valid = 1'b0;
        chk("pre-reset state", 32'(state), 32'(ST_RUN));
        chk("pre-reset level", 32'(fifo_level), 32'd3);
        reset = 1'b0; tick();
        chk("reset enable", 32'(tx_enable), 32'd0);
        chk("reset level", 32'(fifo_level), 32'd0);
        chk("reset state", 32'(state), 32'(ST_IDLE));
        reset = 1'b1;

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            s0_valid = ($urandom_range(0, 99) < 35);
            s1_valid = ($urandom_range(0, 99) < 35);
            s0_data  = $urandom();
            s1_data  = $urandom();
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            reset = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 299) == 0) ws_half = $urandom_range(2, 12);
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
